// File: rtl/shift_pkg.sv
// Shared types and helpers for the serial-in deserializer.
// Optional even-parity framing is enabled with SHIFT_DESER_PARITY_EN.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = 4;
    localparam int MAX_W     = 16;

    // Insert one bit into a word of width w (w <= MAX_W-1), either end.
    function automatic logic [MAX_W-1:0] shift_step(
        input logic [MAX_W-1:0] word,
        input logic             b,
        input logic             lsb_first,
        input int               w
    );
        logic [MAX_W-1:0] r;
        if (lsb_first)
            r = (word >> 1) | ({{(MAX_W-1){1'b0}}, b} << (w - 1));
        else
            r = {word[MAX_W-2:0], b};
        return r;
    endfunction

endpackage

// File: rtl/shift_deser_core.sv
// Shift register, bit counter and IDLE/SHIFT tracking for one frame.
// Frame gains a trailing parity bit when SHIFT_DESER_PARITY_EN is defined.
module shift_deser_core
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             accept,
    input  logic             flush,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             at_last,
    output logic             done,
    output logic [WIDTH-1:0] word
);

`ifdef SHIFT_DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] nxt;
    state_t           state;

    assign nxt     = WIDTH'(shift_step(MAX_W'(shreg), sin, LSB_FIRST, WIDTH));
    assign at_last = (bit_cnt == LAST);
    assign done    = accept && (state == SHIFT) && at_last;

`ifdef SHIFT_DESER_PARITY_EN
    // The closing bit is parity, so the data word is already complete.
    assign word = shreg;
`else
    assign word = nxt;
`endif

    // Shift accepted bits in, count them, return to IDLE on frame end or flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            state   <= IDLE;
        end else if (flush) begin
            shreg   <= '0;
            bit_cnt <= '0;
            state   <= IDLE;
        end else if (accept) begin
            if (at_last) begin
                shreg   <= '0;
                bit_cnt <= '0;
                state   <= IDLE;
            end else begin
                shreg   <= nxt;
                bit_cnt <= bit_cnt + CNT_W'(1);
                state   <= SHIFT;
            end
        end
    end

endmodule

// File: rtl/shift_deser8.sv
// Serial-in parallel-out receiver with a registered valid/ready output slot.
// Define SHIFT_DESER_PARITY_EN for WIDTH data bits plus one even-parity bit.
module shift_deser8
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             sin_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             parity_err
);

    logic             accept;
    logic             at_last;
    logic             done;
    logic [WIDTH-1:0] word;

    // Only the completing bit waits for the slot; a same-edge consume frees it.
    assign sin_ready = !flush && !(at_last && dout_valid && !dout_ready);
    assign accept    = sin_valid && sin_ready;

    shift_deser_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .sin     (sin),
        .accept  (accept),
        .flush   (flush),
        .bit_cnt (bit_cnt),
        .at_last (at_last),
        .done    (done),
        .word    (word)
    );

    // Output slot: load a finished word, release it when consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (done) begin
            dout       <= word;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

`ifdef SHIFT_DESER_PARITY_EN
    // Parity status travels with the word it describes.
    always_ff @(posedge clk) begin
        if (!rst_n)
            parity_err <= 1'b0;
        else if (done)
            parity_err <= (^word) ^ sin;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
